// File: rtl/contador_bcd_display.sv
// Start/stop two-digit BCD up/down counter with configurable modulo, advanced by
// rising edges of a slow divided signal and driving two active-low 7-segment digits.
module contador_bcd_display #(
    parameter int MODULO = 60
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       up_down,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic       running,
    output logic       wrap
);

    generate
        if (MODULO < 2 || MODULO > 100) begin : g_bad_modulo
            $error("contador_bcd_display: MODULO must lie in 2..100");
        end
    endgenerate

    localparam logic [3:0] MAX_U = 4'((MODULO - 1) % 10);
    localparam logic [3:0] MAX_D = 4'((MODULO - 1) / 10);

    typedef enum logic {
        PARADO   = 1'b0,
        CONTANDO = 1'b1
    } state_t;

    // Index 0 = tick_in, index 1 = start_stop; both are sampled as asynchronous levels.
    logic [1:0] async_in;
    logic [1:0] s1_reg, s2_reg, s3_reg;
    logic [1:0] edge_pulse;

    assign async_in = {start_stop, tick_in};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            always_ff @(posedge CLOCK_50) begin
                if (reset) begin
                    s1_reg[gi] <= 1'b0;
                    s2_reg[gi] <= 1'b0;
                    s3_reg[gi] <= 1'b0;
                end else begin
                    s1_reg[gi] <= async_in[gi];
                    s2_reg[gi] <= s1_reg[gi];
                    s3_reg[gi] <= s2_reg[gi];
                end
            end
            assign edge_pulse[gi] = s2_reg[gi] & ~s3_reg[gi];
        end
    endgenerate

    logic tick_pulse, ss_pulse;
    assign tick_pulse = edge_pulse[0];
    assign ss_pulse   = edge_pulse[1];

    state_t state_reg, state_next;
    logic   running_reg;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_reg   <= PARADO;
            running_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            running_reg <= (state_next == CONTANDO);
        end
    end

    always_comb begin
        state_next = state_reg;
        if (ss_pulse) begin
            state_next = (state_reg == PARADO) ? CONTANDO : PARADO;
        end
    end

    logic [3:0] unidade_reg, dezena_reg;
    logic       wrap_reg;

    // The tick is judged against the pre-toggle state, so a coincident stop still counts.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            unidade_reg <= 4'd0;
            dezena_reg  <= 4'd0;
            wrap_reg    <= 1'b0;
        end else begin
            wrap_reg <= 1'b0;
            if (clear) begin
                unidade_reg <= 4'd0;
                dezena_reg  <= 4'd0;
            end else if (tick_pulse && state_reg == CONTANDO) begin
                if (up_down) begin
                    if (unidade_reg == MAX_U && dezena_reg == MAX_D) begin
                        unidade_reg <= 4'd0;
                        dezena_reg  <= 4'd0;
                        wrap_reg    <= 1'b1;
                    end else if (unidade_reg == 4'd9) begin
                        unidade_reg <= 4'd0;
                        dezena_reg  <= dezena_reg + 4'd1;
                    end else begin
                        unidade_reg <= unidade_reg + 4'd1;
                    end
                end else begin
                    if (unidade_reg == 4'd0 && dezena_reg == 4'd0) begin
                        unidade_reg <= MAX_U;
                        dezena_reg  <= MAX_D;
                        wrap_reg    <= 1'b1;
                    end else if (unidade_reg == 4'd0) begin
                        unidade_reg <= 4'd9;
                        dezena_reg  <= dezena_reg - 4'd1;
                    end else begin
                        unidade_reg <= unidade_reg - 4'd1;
                    end
                end
            end
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    logic [3:0] digit [2];
    logic [6:0] hex   [2];

    assign digit[0] = unidade_reg;
    assign digit[1] = dezena_reg;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_decode
            assign hex[gi] = seg7(digit[gi]);
        end
    endgenerate

    assign HEX0    = hex[0];
    assign HEX1    = hex[1];
    assign running = running_reg;
    assign wrap    = wrap_reg;

endmodule

// File: tb/tb_contador_bcd_display.sv
// Scoreboard bench: stimulus queues expected display state per cycle for a MODULO=60
// and a MODULO=8 instance; a negedge monitor pops and compares when each entry is due.
module tb_contador_bcd_display;

    logic clk = 1'b0;
    logic reset, tick_in, start_stop, clear, up_down;
    logic [6:0] h0_60, h1_60, h0_8, h1_8;
    logic run_60, run_8, wrap_60, wrap_8;

    always #10 clk = ~clk;

    contador_bcd_display #(.MODULO(60)) dut60 (
        .CLOCK_50(clk), .reset(reset), .tick_in(tick_in), .start_stop(start_stop),
        .clear(clear), .up_down(up_down), .HEX0(h0_60), .HEX1(h1_60),
        .running(run_60), .wrap(wrap_60)
    );

    contador_bcd_display #(.MODULO(8)) dut8 (
        .CLOCK_50(clk), .reset(reset), .tick_in(tick_in), .start_stop(start_stop),
        .clear(clear), .up_down(up_down), .HEX0(h0_8), .HEX1(h1_8),
        .running(run_8), .wrap(wrap_8)
    );

    typedef struct {
        int         due;
        logic [6:0] a1, a0, b1, b0;
        logic       run, wa, wb;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    logic [6:0] seg [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    int cyc = 0;
    int errors = 0, checks = 0;
    int v60 = 0, v8 = 0;
    bit run_m = 1'b0;
    int ew60 = 0, ew8 = 0, aw60 = 0, aw8 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h, required %0h", name, cyc, act, exp_v);
        end
    endtask

    // Monitor: counts wrap cycles and checks every scoreboard entry that falls due.
    always @(negedge clk) begin
        if (wrap_60 === 1'b1) aw60++;
        if (wrap_8 === 1'b1) aw8++;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due < cyc) begin
                chk("missed_entry", cyc, e.due);
            end else begin
                chk("hex_m60", int'({h1_60, h0_60}), int'({e.a1, e.a0}));
                chk("hex_m8", int'({h1_8, h0_8}), int'({e.b1, e.b0}));
                chk("running_m60", int'(run_60), int'(e.run));
                chk("running_m8", int'(run_8), int'(e.run));
                chk("wrap_m60", int'(wrap_60), int'(e.wa));
                chk("wrap_m8", int'(wrap_8), int'(e.wb));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int due, input bit wa, input bit wb);
        exp_t x;
        x.due = due;
        x.a1 = seg[v60 / 10]; x.a0 = seg[v60 % 10];
        x.b1 = seg[v8 / 10];  x.b0 = seg[v8 % 10];
        x.run = run_m; x.wa = wa; x.wb = wb;
        sb.push_back(x);
    endtask

    task automatic model_tick(output bit wa, output bit wb);
        wa = 1'b0; wb = 1'b0;
        if (run_m) begin
            if (up_down) begin
                if (v60 == 59) begin v60 = 0; wa = 1'b1; end else v60++;
                if (v8 == 7) begin v8 = 0; wb = 1'b1; end else v8++;
            end else begin
                if (v60 == 0) begin v60 = 59; wa = 1'b1; end else v60--;
                if (v8 == 0) begin v8 = 7; wb = 1'b1; end else v8--;
            end
        end
        if (wa) ew60++;
        if (wb) ew8++;
    endtask

    // A tick_in rise at negedge of cycle N shows up in the count after posedge N+3.
    task automatic do_tick();
        bit wa, wb;
        tick_in = 1'b1;
        model_tick(wa, wb);
        push(cyc + 3, wa, wb);
        push(cyc + 4, 1'b0, 1'b0);
        step(4);
        tick_in = 1'b0;
        step(4);
    endtask

    task automatic toggle_ss();
        start_stop = 1'b1;
        run_m = ~run_m;
        push(cyc + 3, 1'b0, 1'b0);
        step(4);
        start_stop = 1'b0;
        step(4);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        v60 = 0; v8 = 0;
        push(cyc + 1, 1'b0, 1'b0);
        step(1);
        clear = 1'b0;
        step(3);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit wa, wb;
        reset = 1'b1; tick_in = 1'b0; start_stop = 1'b0; clear = 1'b0; up_down = 1'b1;
        step(3);
        push(cyc + 1, 1'b0, 1'b0);
        step(1);
        reset = 1'b0;
        step(2);

        // Idle: ticks without a start must not move the count.
        repeat (10) do_tick();

        toggle_ss();
        repeat (12) do_tick();
        repeat (47) do_tick();
        do_tick();

        do_clear();
        up_down = 1'b0;
        do_tick();
        repeat (22) do_tick();

        // Clear lands in the same cycle as the tick pulse at count 37.
        tick_in = 1'b1;
        step(2);
        clear = 1'b1;
        v60 = 0; v8 = 0;
        push(cyc + 1, 1'b0, 1'b0);
        push(cyc + 2, 1'b0, 1'b0);
        step(1);
        clear = 1'b0;
        step(1);
        tick_in = 1'b0;
        step(4);

        up_down = 1'b1;
        repeat (5) do_tick();

        // Stop pulse coincident with a tick at 05: tick counts, then stop.
        tick_in = 1'b1;
        start_stop = 1'b1;
        model_tick(wa, wb);
        run_m = 1'b0;
        push(cyc + 3, wa, wb);
        push(cyc + 4, 1'b0, 1'b0);
        step(4);
        tick_in = 1'b0;
        start_stop = 1'b0;
        step(4);
        do_tick();

        toggle_ss();
        repeat (38) do_tick();

        // Reset at 44 with tick_in held high across deassertion.
        reset = 1'b1;
        tick_in = 1'b1;
        v60 = 0; v8 = 0; run_m = 1'b0;
        push(cyc + 1, 1'b0, 1'b0);
        step(3);
        reset = 1'b0;
        step(8);
        push(cyc + 1, 1'b0, 1'b0);
        step(2);
        tick_in = 1'b0;
        step(2);

        chk("wrap_total_m60", aw60, ew60);
        chk("wrap_total_m8", aw8, ew8);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
